// File: rtl/exec_writeback_stage_pkg.sv
// Shared execute-stage definitions: ALU opcodes, default widths, zero-register index.
package exec_writeback_stage_pkg;
  localparam int DATA_W_DEF     = 32;
  localparam int IMM_W_DEF      = 16;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int ZERO_REG       = 0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;
endpackage

// File: rtl/exec_alu.sv
// Combinational ALU; overflow is reported only for ADD/SUB.
module exec_alu
  import exec_writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALUOp,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  logic [SHW-1:0] shamt;
  assign shamt = B[SHW-1:0];

  always_comb begin
    Result   = '0;
    Overflow = 1'b0;
    unique case (ALUOp)
      ALU_ADD: begin
        Result   = A + B;
        Overflow = (A[MSB] == B[MSB]) && (Result[MSB] != A[MSB]);
      end
      ALU_SUB: begin
        Result   = A - B;
        Overflow = (A[MSB] != B[MSB]) && (Result[MSB] != A[MSB]);
      end
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_XOR: Result = A ^ B;
      ALU_SLT: Result = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLL: Result = A << shamt;
      ALU_SRL: Result = A >> shamt;
      default: Result = '0;
    endcase
  end
endmodule

// File: rtl/exec_writeback_stage.sv
// Execute stage with one-level result forwarding; the stage-3 register drives the
// register-file write port directly.
module exec_writeback_stage
  import exec_writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int IMM_WIDTH      = IMM_W_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [DATA_WIDTH-1:0]     S2_ReadData1,
  input  logic [DATA_WIDTH-1:0]     S2_ReadData2,
  input  logic [REG_ADDR_WIDTH-1:0] S2_ReadSelect1,
  input  logic [REG_ADDR_WIDTH-1:0] S2_ReadSelect2,
  input  logic [IMM_WIDTH-1:0]      S2_Imm,
  input  logic                      S2_DataSrc,
  input  logic [2:0]                S2_ALUOp,
  input  logic [REG_ADDR_WIDTH-1:0] S2_WriteSelect,
  input  logic                      S2_WriteEnable,
  output logic [DATA_WIDTH-1:0]     S3_Result,
  output logic [REG_ADDR_WIDTH-1:0] S3_WriteSelect,
  output logic                      S3_WriteEnable,
  output logic                      S3_Overflow,
  output logic                      FwdA,
  output logic                      FwdB
);
  localparam logic [REG_ADDR_WIDTH-1:0] RZ = REG_ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] wsel_q;
  logic                      we_q, ov_q, ov_d;
  logic [DATA_WIDTH-1:0]     imm_ext, op_a, op_b;

  // we_q is already cleared for register 0, so a stale zero-index result never forwards.
  assign FwdA = we_q && (wsel_q == S2_ReadSelect1) && (S2_ReadSelect1 != RZ);
  assign FwdB = !S2_DataSrc && we_q && (wsel_q == S2_ReadSelect2) && (S2_ReadSelect2 != RZ);

  assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){S2_Imm[IMM_WIDTH-1]}}, S2_Imm};
  assign op_a    = FwdA ? result_q : S2_ReadData1;
  assign op_b    = S2_DataSrc ? imm_ext : (FwdB ? result_q : S2_ReadData2);

  exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .A        (op_a),
    .B        (op_b),
    .ALUOp    (S2_ALUOp),
    .Result   (result_d),
    .Overflow (ov_d)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      result_q <= '0;
      wsel_q   <= '0;
      we_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      wsel_q   <= S2_WriteSelect;
      we_q     <= S2_WriteEnable && (S2_WriteSelect != RZ);
      ov_q     <= ov_d;
    end
  end

  assign S3_Result      = result_q;
  assign S3_WriteSelect = wsel_q;
  assign S3_WriteEnable = we_q;
  assign S3_Overflow    = ov_q;
endmodule

// File: tb/tb_exec_writeback_stage.sv
// Directed-vector bench for exec_writeback_stage with hand-computed expectations.
module tb_exec_writeback_stage;
  logic        Clk, Reset;
  logic [31:0] S2_ReadData1, S2_ReadData2;
  logic [4:0]  S2_ReadSelect1, S2_ReadSelect2, S2_WriteSelect;
  logic [15:0] S2_Imm;
  logic        S2_DataSrc, S2_WriteEnable;
  logic [2:0]  S2_ALUOp;
  logic [31:0] S3_Result;
  logic [4:0]  S3_WriteSelect;
  logic        S3_WriteEnable, S3_Overflow, FwdA, FwdB;

  int n_chk  = 0;
  int n_fail = 0;

  exec_writeback_stage dut (
    .Clk(Clk), .Reset(Reset),
    .S2_ReadData1(S2_ReadData1), .S2_ReadData2(S2_ReadData2),
    .S2_ReadSelect1(S2_ReadSelect1), .S2_ReadSelect2(S2_ReadSelect2),
    .S2_Imm(S2_Imm), .S2_DataSrc(S2_DataSrc), .S2_ALUOp(S2_ALUOp),
    .S2_WriteSelect(S2_WriteSelect), .S2_WriteEnable(S2_WriteEnable),
    .S3_Result(S3_Result), .S3_WriteSelect(S3_WriteSelect),
    .S3_WriteEnable(S3_WriteEnable), .S3_Overflow(S3_Overflow),
    .FwdA(FwdA), .FwdB(FwdB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] alu, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] s1, input logic [4:0] s2, input logic ds,
                    input logic [15:0] imm, input logic [4:0] ws, input logic we);
    S2_ALUOp = alu; S2_ReadData1 = a; S2_ReadData2 = b;
    S2_ReadSelect1 = s1; S2_ReadSelect2 = s2; S2_DataSrc = ds;
    S2_Imm = imm; S2_WriteSelect = ws; S2_WriteEnable = we;
    #1;
  endtask

  task automatic step;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0;
    op(3'b000, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 16'd0, 5'd0, 1'b0);
    step; step;
    chk("rst_result", S3_Result, 32'd0);
    chk("rst_we", {31'd0, S3_WriteEnable}, 32'd0);

    // Get S3 into a live, write-enabled state, then yank reset mid-cycle.
    Reset = 1'b1;
    op(3'b000, 32'd1, 32'd2, 5'd1, 5'd4, 1'b0, 16'd0, 5'd5, 1'b1);
    step;
    chk("pre_rst_result", S3_Result, 32'd3);
    chk("pre_rst_we", {31'd0, S3_WriteEnable}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_result", S3_Result, 32'd0);
    chk("async_rst_wsel", {27'd0, S3_WriteSelect}, 32'd0);
    chk("async_rst_we", {31'd0, S3_WriteEnable}, 32'd0);
    chk("async_rst_ov", {31'd0, S3_Overflow}, 32'd0);
    step;
    chk("held_rst_result", S3_Result, 32'd0);

    Reset = 1'b1;
    op(3'b000, 32'd5, 32'd7, 5'd1, 5'd4, 1'b0, 16'd0, 5'd3, 1'b1);
    step;
    chk("add_result", S3_Result, 32'd12);
    chk("add_wsel", {27'd0, S3_WriteSelect}, 32'd3);
    chk("add_we", {31'd0, S3_WriteEnable}, 32'd1);

    // Immediate path: ReadSelect2 matches the pending write but must not forward.
    op(3'b000, 32'd10, 32'd100, 5'd4, 5'd3, 1'b1, 16'hFFFF, 5'd6, 1'b1);
    chk("imm_fwdb", {31'd0, FwdB}, 32'd0);
    chk("imm_fwda", {31'd0, FwdA}, 32'd0);
    step;
    chk("imm_result", S3_Result, 32'd9);

    op(3'b000, 32'd3, 32'd4, 5'd0, 5'd0, 1'b0, 16'd0, 5'd2, 1'b1);
    step;
    chk("fwd_setup", S3_Result, 32'd7);
    op(3'b000, 32'd0, 32'd0, 5'd2, 5'd2, 1'b0, 16'd0, 5'd7, 1'b1);
    chk("fwd_a", {31'd0, FwdA}, 32'd1);
    chk("fwd_b", {31'd0, FwdB}, 32'd1);
    step;
    chk("fwd_result", S3_Result, 32'd14);

    op(3'b000, 32'd90, 32'd9, 5'd1, 5'd1, 1'b0, 16'd0, 5'd0, 1'b1);
    step;
    chk("r0_result", S3_Result, 32'd99);
    chk("r0_we", {31'd0, S3_WriteEnable}, 32'd0);
    op(3'b011, 32'd0, 32'd5, 5'd0, 5'd8, 1'b0, 16'd0, 5'd8, 1'b1);
    chk("r0_fwda", {31'd0, FwdA}, 32'd0);
    step;
    chk("or_result", S3_Result, 32'd5);

    op(3'b000, 32'h7FFFFFFF, 32'd1, 5'd9, 5'd10, 1'b0, 16'd0, 5'd9, 1'b1);
    step;
    chk("ovf_add_result", S3_Result, 32'h80000000);
    chk("ovf_add_flag", {31'd0, S3_Overflow}, 32'd1);
    op(3'b001, 32'h80000000, 32'd1, 5'd11, 5'd10, 1'b0, 16'd0, 5'd12, 1'b1);
    step;
    chk("ovf_sub_result", S3_Result, 32'h7FFFFFFF);
    chk("ovf_sub_flag", {31'd0, S3_Overflow}, 32'd1);
    op(3'b101, 32'hFFFFFFFF, 32'd1, 5'd13, 5'd14, 1'b0, 16'd0, 5'd13, 1'b1);
    step;
    chk("slt_result", S3_Result, 32'd1);
    chk("slt_ov", {31'd0, S3_Overflow}, 32'd0);

    op(3'b111, 32'h80000000, 32'd33, 5'd14, 5'd15, 1'b0, 16'd0, 5'd14, 1'b1);
    step;
    chk("srl_result", S3_Result, 32'h40000000);
    op(3'b110, 32'd1, 32'd0, 5'd15, 5'd16, 1'b1, 16'd4, 5'd15, 1'b1);
    step;
    chk("sll_result", S3_Result, 32'd16);
    op(3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd16, 5'd17, 1'b0, 16'd0, 5'd16, 1'b1);
    step;
    chk("and_result", S3_Result, 32'h00F000F0);

    op(3'b100, 32'h000000F0, 32'h000000FF, 5'd17, 5'd18, 1'b0, 16'd0, 5'd11, 1'b0);
    step;
    chk("xor_result", S3_Result, 32'h0000000F);
    chk("xor_we", {31'd0, S3_WriteEnable}, 32'd0);
    op(3'b000, 32'd1, 32'd2, 5'd11, 5'd11, 1'b0, 16'd0, 5'd18, 1'b1);
    chk("dis_fwda", {31'd0, FwdA}, 32'd0);
    chk("dis_fwdb", {31'd0, FwdB}, 32'd0);
    step;
    chk("dis_result", S3_Result, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_writeback_stage.md
Name: exec_writeback_stage

Overview:
- Consumer end of the stage-2 pipeline register. Takes the registered stage-2 operands and control fields, selects operand B, resolves one level of result forwarding, and executes the ALU operation.
- Latches the outcome in the stage-3 register, whose outputs drive the register-file write port directly.
- Sits between the stage-2 register and the register file: it closes the datapath loop.

Parameters:
- DATA_WIDTH, 32, operand/result width
- IMM_WIDTH, 16, immediate width; sign-extended to DATA_WIDTH
- REG_ADDR_WIDTH, 5, register select width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- S2_ReadData1  in  DATA_WIDTH  operand A from stage-2 register
- S2_ReadData2  in  DATA_WIDTH  operand B (register) from stage-2 register
- S2_ReadSelect1  in  REG_ADDR_WIDTH  source register index of operand A
- S2_ReadSelect2  in  REG_ADDR_WIDTH  source register index of operand B
- S2_Imm  in  IMM_WIDTH  immediate
- S2_DataSrc  in  1  1 = operand B is immediate, 0 = register
- S2_ALUOp  in  3  ALU operation
- S2_WriteSelect  in  REG_ADDR_WIDTH  destination register
- S2_WriteEnable  in  1  destination write request
- S3_Result  out  DATA_WIDTH  registered ALU result; register-file write data
- S3_WriteSelect  out  REG_ADDR_WIDTH  registered destination; register-file write address
- S3_WriteEnable  out  1  registered write enable; register-file write enable
- S3_Overflow  out  1  registered signed overflow of ADD/SUB
- FwdA  out  1  combinational; operand A taken from S3_Result this cycle
- FwdB  out  1  combinational; operand B taken from S3_Result this cycle

Behaviour:
- Reset low, asynchronous: S3_Result = 0, S3_WriteSelect = 0, S3_WriteEnable = 0, S3_Overflow = 0. All are held at these values while Reset is low.
- Reset deasserted mid-stream: the first rising edge with Reset high captures the current stage-2 inputs. No partial state survives reset.
- Latency: stage-2 inputs present before edge N produce stage-3 outputs after edge N (1 cycle). No stall; a new operation is accepted every cycle.
- Immediate handling: Imm sign-extended to DATA_WIDTH.
  - Operand B = DataSrc ? ext(Imm) : fwdB_value.
  - When DataSrc = 1, FwdB = 0 regardless of ReadSelect2.
- Forwarding condition for operand A:
  - FwdA = S3_WriteEnable & (S3_WriteSelect == S2_ReadSelect1) & (S2_ReadSelect1 != 0).
  - FwdA = 1 → A = S3_Result; otherwise A = S2_ReadData1.
- Forwarding condition for operand B: FwdB is the same test on ReadSelect2, additionally gated by DataSrc = 0.
- Both operands may forward in the same cycle. Both then take S3_Result.
- ALUOp encoding (all modulo 2^DATA_WIDTH):
  - 000 ADD
  - 001 SUB (A − B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: signed A < B → 1, else 0
  - 110 SLL: A << B[4:0]
  - 111 SRL: logical A >> B[4:0]
- Overflow: S3_Overflow = signed overflow for ADD/SUB, 0 for all other ops.
  - Captured every cycle, independent of WriteEnable.
- Register 0 is hardwired zero:
  - S3_WriteEnable <= S2_WriteEnable & (S2_WriteSelect != 0).
  - S3_Result is still captured.
- A write that is not enabled (WriteEnable 0) never triggers forwarding, even when selects match.

Decomposition:
- Shared package: ALUOp constants (ALU_ADD … ALU_SRL), DATA_WIDTH/IMM_WIDTH/REG_ADDR_WIDTH defaults, and a zero-register index constant. The decoder stage and this block both use them.
- One combinational sub-module, exec_alu. Inputs A, B, ALUOp; outputs Result, Overflow.
- The forwarding muxes and the stage-3 register stay in exec_writeback_stage.

Test Plan:
- Reset: drive Reset=0 mid-operation with S3_WriteEnable=1 → all S3 outputs 0 immediately, before the next edge. Release, then apply ADD 5+7 to reg 3 → after 1 edge S3_Result=12, S3_WriteSelect=3, S3_WriteEnable=1.
- Immediate path: DataSrc=1, Imm=16'hFFFF, ReadData1=10, ADD → S3_Result=9. FwdB=0 even though ReadSelect2 matches S3_WriteSelect.
- Back-to-back forwarding:
  - Cycle 1: reg2 <= 3+4.
  - Cycle 2: ReadSelect1=ReadSelect2=2, stale ReadData=0, ADD → FwdA=FwdB=1, S3_Result=14.
- Register-0 rules: write reg 0 with result 99 → S3_WriteEnable=0. The next op reads ReadSelect1=0 with ReadData1=0 → FwdA=0.
- Overflow/SLT: ADD 32'h7FFFFFFF+1 → S3_Result=32'h80000000, S3_Overflow=1. SLT −1 < 1 → S3_Result=1, S3_Overflow=0.
- Shifts/disabled write: SRL 32'h80000000 by B=33 → uses B[4:0]=1 → 32'h40000000. Then issue an op with WriteEnable=0 and a matching select → the following op shows FwdA=0.
